// File: rtl/rv32_csr_pkg.sv
// Shared definitions for the RV32 machine-mode CSR unit.
// Holds CSR addresses, mip/mie bit indices, interrupt cause codes, mstatus
// field indices, the csr_op (funct3) encoding and the read-modify-write helper.
package rv32_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_TIME      = 12'hC01;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_TIMEH     = 12'hC81;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    // mip/mie bit positions
    localparam int IRQ_MSI       = 3;
    localparam int IRQ_MTI       = 7;
    localparam int IRQ_MEI       = 11;
    localparam int IRQ_PLAT_BASE = 16;

    // interrupt cause codes (platform line i uses CAUSE_PLAT_BASE + i)
    localparam logic [4:0] CAUSE_MSI       = 5'd3;
    localparam logic [4:0] CAUSE_MTI       = 5'd7;
    localparam logic [4:0] CAUSE_MEI       = 5'd11;
    localparam logic [4:0] CAUSE_PLAT_BASE = 5'd16;

    // mstatus fields
    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam logic [31:0] MSTATUS_RST = 32'h0000_1800;  // MPP=11 hardwired
    localparam logic [31:0] MISA_VAL    = 32'h4000_0100;  // RV32I

    typedef enum logic [2:0] {
        CSR_OP_RW  = 3'b001,
        CSR_OP_RS  = 3'b010,
        CSR_OP_RC  = 3'b011,
        CSR_OP_RWI = 3'b101,
        CSR_OP_RSI = 3'b110,
        CSR_OP_RCI = 3'b111
    } csr_op_e;

    // registered interrupt request/cause pair
    typedef struct packed {
        logic        req;
        logic [31:0] cause;
    } irq_resp_t;

    // New CSR value from the pre-write value and the operand.
    function automatic logic [31:0] csr_apply(input logic [2:0] op,
                                              input logic [31:0] old,
                                              input logic [31:0] wdata);
        logic [31:0] src;
        src = op[2] ? {27'd0, wdata[4:0]} : wdata;
        case (csr_op_e'(op))
            CSR_OP_RW, CSR_OP_RWI: return src;
            CSR_OP_RS, CSR_OP_RSI: return old | src;
            CSR_OP_RC, CSR_OP_RCI: return old & ~src;
            default:               return old;
        endcase
    endfunction

endpackage

// File: rtl/rv32_csr_counter.sv
// CNT_W-bit performance counter presented as a 64-bit value (upper bits 0).
// Ports: clk, rst (async, active high), inc, wr_lo/wr_hi half-write strobes,
// wdata (32-bit half value), cnt (64-bit zero-extended count).
// A half-write replaces only that half and suppresses inc for that cycle;
// an increment carries from the low into the high half in the same cycle.
module rv32_csr_counter #(
    parameter int CNT_W = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [63:0]      cur, nxt;

    assign cur = 64'(cnt_q);
    assign cnt = cur;

    always_comb begin
        nxt = cur;
        if (wr_lo)      nxt[31:0]  = wdata;
        else if (wr_hi) nxt[63:32] = wdata;  // bits above CNT_W are dropped
        else if (inc)   nxt        = cur + 64'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= nxt[CNT_W-1:0];
    end

endmodule

// File: rtl/rv32_csr_unit.sv
// Machine-mode CSR file for the RV32 core: mstatus/mie/mtvec/mscratch/mepc/
// mcause/mtval/mip, 64-bit mcycle/minstret, time shadow, registered
// interrupt arbitration and trap-vector generation.
// Ports: clk, rst (async, active high); CSR access csr_addr/op/we/wdata ->
// csr_rdata (pre-write, combinational), csr_illegal; instret_inc; mtime;
// trap inputs exception_trigger/cause/pc/value, mret_trigger; interrupt
// sources irq_soft/timer/ext/plat; outputs irq_req, irq_cause (registered),
// trap_vector, mepc_out, mstatus_out.
// Config macro CSR_VECTORED_MTVEC_EN: when defined, mtvec MODE=01 is stored
// and interrupts vector to BASE+4*code; otherwise MODE is hardwired 00.
module rv32_csr_unit
    import rv32_csr_pkg::*;
#(
    parameter int          NUM_IRQ = 4,
    parameter logic [31:0] HART_ID = 32'd0,
    parameter int          CNT_W   = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [11:0]        csr_addr,
    input  logic [2:0]         csr_op,
    input  logic               csr_we,
    input  logic [31:0]        csr_wdata,
    output logic [31:0]        csr_rdata,
    output logic               csr_illegal,
    input  logic               instret_inc,
    input  logic [63:0]        mtime,
    input  logic               exception_trigger,
    input  logic [31:0]        exception_cause,
    input  logic [31:0]        exception_pc,
    input  logic [31:0]        exception_value,
    input  logic               mret_trigger,
    input  logic               irq_soft,
    input  logic               irq_timer,
    input  logic               irq_ext,
    input  logic [NUM_IRQ-1:0] irq_plat,
    output logic               irq_req,
    output logic [31:0]        irq_cause,
    output logic [31:0]        trap_vector,
    output logic [31:0]        mepc_out,
    output logic [31:0]        mstatus_out
);

    localparam logic [31:0] MIE_MASK =
        32'h888 | (((32'd1 << NUM_IRQ) - 32'd1) << IRQ_PLAT_BASE);

    logic        mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
    logic [31:0] mie_q, mie_d, mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
    logic [29:0] tvec_base_q, tvec_base_d;
    logic        tvec_mode_q;
    logic [31:0] mip_q, mip_now, pend, mstatus_rd, wr_val;
    logic [63:0] mcycle, minstret;
    logic        hit, csr_wr;
    logic [4:0]  irq_code;
    irq_resp_t   irq_q, irq_d;
    logic        unused_pc_lsb;

    assign unused_pc_lsb = ^exception_pc[1:0];

    // Either trap trigger drops a CSR write issued in the same cycle.
    assign csr_wr = csr_we & ~exception_trigger & ~mret_trigger;
    assign wr_val = csr_apply(csr_op, csr_rdata, csr_wdata);

    always_comb begin
        mstatus_rd               = MSTATUS_RST;
        mstatus_rd[MSTATUS_MIE]  = mst_mie_q;
        mstatus_rd[MSTATUS_MPIE] = mst_mpie_q;
    end

    // ---- read mux / legality ----
    always_comb begin
        hit       = 1'b1;
        csr_rdata = 32'd0;
        case (csr_addr)
            CSR_MSTATUS:               csr_rdata = mstatus_rd;
            CSR_MISA:                  csr_rdata = MISA_VAL;
            CSR_MIE:                   csr_rdata = mie_q;
            CSR_MTVEC:                 csr_rdata = {tvec_base_q, 1'b0, tvec_mode_q};
            CSR_MSCRATCH:              csr_rdata = mscratch_q;
            CSR_MEPC:                  csr_rdata = mepc_q;
            CSR_MCAUSE:                csr_rdata = mcause_q;
            CSR_MTVAL:                 csr_rdata = mtval_q;
            CSR_MIP:                   csr_rdata = mip_q;
            CSR_MCYCLE, CSR_CYCLE:     csr_rdata = mcycle[31:0];
            CSR_MCYCLEH, CSR_CYCLEH:   csr_rdata = mcycle[63:32];
            CSR_MINSTRET, CSR_INSTRET: csr_rdata = minstret[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: csr_rdata = minstret[63:32];
            CSR_TIME:                  csr_rdata = mtime[31:0];
            CSR_TIMEH:                 csr_rdata = mtime[63:32];
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: csr_rdata = 32'd0;
            CSR_MHARTID:               csr_rdata = HART_ID;
            default:                   hit = 1'b0;
        endcase
    end

    assign csr_illegal = ~hit | (csr_we & (csr_addr[11:10] == 2'b11));

    // ---- next state: trap > mret > CSR write ----
    always_comb begin
        mst_mie_d   = mst_mie_q;
        mst_mpie_d  = mst_mpie_q;
        mie_d       = mie_q;
        tvec_base_d = tvec_base_q;
        mscratch_d  = mscratch_q;
        mepc_d      = mepc_q;
        mcause_d    = mcause_q;
        mtval_d     = mtval_q;
        if (exception_trigger) begin
            mst_mpie_d = mst_mie_q;
            mst_mie_d  = 1'b0;
            mepc_d     = {exception_pc[31:2], 2'b00};
            mcause_d   = exception_cause;
            mtval_d    = exception_value;
        end else if (mret_trigger) begin
            mst_mie_d  = mst_mpie_q;
            mst_mpie_d = 1'b1;
        end else if (csr_we) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mst_mie_d  = wr_val[MSTATUS_MIE];
                    mst_mpie_d = wr_val[MSTATUS_MPIE];
                end
                CSR_MIE:      mie_d       = wr_val & MIE_MASK;
                CSR_MTVEC:    tvec_base_d = wr_val[31:2];
                CSR_MSCRATCH: mscratch_d  = wr_val;
                CSR_MEPC:     mepc_d      = {wr_val[31:2], 2'b00};  // IALIGN=32
                CSR_MCAUSE:   mcause_d    = wr_val;
                CSR_MTVAL:    mtval_d     = wr_val;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mst_mie_q   <= 1'b0;
            mst_mpie_q  <= 1'b0;
            mie_q       <= '0;
            tvec_base_q <= '0;
            mscratch_q  <= '0;
            mepc_q      <= '0;
            mcause_q    <= '0;
            mtval_q     <= '0;
            mip_q       <= '0;
            irq_q       <= '0;
        end else begin
            mst_mie_q   <= mst_mie_d;
            mst_mpie_q  <= mst_mpie_d;
            mie_q       <= mie_d;
            tvec_base_q <= tvec_base_d;
            mscratch_q  <= mscratch_d;
            mepc_q      <= mepc_d;
            mcause_q    <= mcause_d;
            mtval_q     <= mtval_d;
            mip_q       <= mip_now;
            irq_q       <= irq_d;
        end
    end

`ifdef CSR_VECTORED_MTVEC_EN
    // MODE 1x is not supported: such a write keeps the old MODE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tvec_mode_q <= 1'b0;
        else if (csr_wr && csr_addr == CSR_MTVEC && !wr_val[1])
            tvec_mode_q <= wr_val[0];
    end
`else
    assign tvec_mode_q = 1'b0;
`endif

    always_comb begin
        trap_vector = {tvec_base_q, 2'b00};
        if (tvec_mode_q && exception_cause[31])
            trap_vector = {tvec_base_q, 2'b00} + {25'd0, exception_cause[4:0], 2'b00};
    end

    // ---- interrupts ----
    // Arbitration uses this cycle's sources against the post-edge mie/MIE,
    // so irq_req follows a source by one cycle and drops right after a trap.
    always_comb begin
        mip_now                             = '0;
        mip_now[IRQ_MSI]                    = irq_soft;
        mip_now[IRQ_MTI]                    = irq_timer;
        mip_now[IRQ_MEI]                    = irq_ext;
        mip_now[IRQ_PLAT_BASE +: NUM_IRQ]   = irq_plat;
    end

    assign pend = mip_now & mie_d;

    always_comb begin
        irq_code = 5'd0;
        // lowest-priority first so later checks override
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (pend[IRQ_PLAT_BASE + i]) irq_code = CAUSE_PLAT_BASE + 5'(i);
        if (pend[IRQ_MTI]) irq_code = CAUSE_MTI;
        if (pend[IRQ_MSI]) irq_code = CAUSE_MSI;
        if (pend[IRQ_MEI]) irq_code = CAUSE_MEI;
    end

    always_comb begin
        irq_d.req   = mst_mie_d & (|pend);
        irq_d.cause = irq_d.req ? {1'b1, 26'd0, irq_code} : 32'd0;
    end

    assign irq_req     = irq_q.req;
    assign irq_cause   = irq_q.cause;
    assign mepc_out    = mepc_q;
    assign mstatus_out = mstatus_rd;

    // ---- counters ----
    rv32_csr_counter #(.CNT_W(CNT_W)) u_mcycle (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .wr_lo (csr_wr && csr_addr == CSR_MCYCLE),
        .wr_hi (csr_wr && csr_addr == CSR_MCYCLEH),
        .wdata (wr_val),
        .cnt   (mcycle)
    );

    rv32_csr_counter #(.CNT_W(CNT_W)) u_minstret (
        .clk   (clk),
        .rst   (rst),
        .inc   (instret_inc),
        .wr_lo (csr_wr && csr_addr == CSR_MINSTRET),
        .wr_hi (csr_wr && csr_addr == CSR_MINSTRETH),
        .wdata (wr_val),
        .cnt   (minstret)
    );

endmodule
